// File: rtl/vmem_scheduler.sv
// vmem_scheduler: frame sequencer and port arbiter for the single-port video memory
//   Clck, Reset            clock (posedge) and asynchronous active-low reset
//   working                level; rising edge starts frames, low stops after the current frame
//   paint_start/done       continuation pulse to / completion pulse from the painter
//   paint_addr/color/we    painter write port (range-checked against MEM_DEPTH)
//   flash_start/done       continuation pulse to / completion pulse from screenFlash
//   flash_addr             screenFlash read address
//   mem_addr/data/wren     RAM pins, muxed combinationally from the owning requester
//   busy, phase            registered status, phase 0=IDLE 1=PAINT 2=GAP 3=FLASH
//   frame_count            completed frames, wraps 255->0
//   err_range, err_timeout sticky error flags, cleared only by Reset
module vmem_scheduler #(
    parameter int ADDR_BITS      = 11,
    parameter int COLOR_BITS     = 3,
    parameter int MEM_DEPTH      = 1122,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                  Clck,
    input  logic                  Reset,
    input  logic                  working,
    output logic                  paint_start,
    input  logic                  paint_done,
    input  logic [ADDR_BITS-1:0]  paint_addr,
    input  logic [COLOR_BITS-1:0] paint_color,
    input  logic                  paint_we,
    output logic                  flash_start,
    input  logic                  flash_done,
    input  logic [ADDR_BITS-1:0]  flash_addr,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [COLOR_BITS-1:0] mem_data,
    output logic                  mem_wren,
    output logic                  busy,
    output logic [1:0]            phase,
    output logic [7:0]            frame_count,
    output logic                  err_range,
    output logic                  err_timeout
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, PAINT = 2'd1, GAP = 2'd2, FLASH = 2'd3} state_t;
    state_t        state_q, state_d;
    logic          working_q, paint_start_q, flash_start_q, busy_q, err_range_q, err_timeout_q;
    logic [7:0]    frame_count_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          in_paint, in_flash, in_range, tmo_hit, bad_write, frame_done, timed_out;

    assign in_paint   = state_q == PAINT;
    assign in_flash   = state_q == FLASH;
    assign in_range   = 32'(paint_addr) < MEM_DEPTH;
    assign tmo_hit    = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign bad_write  = in_paint && paint_we && !in_range;
    assign frame_done = in_flash && flash_done;
    // a done arriving in the last allowed cycle still wins over the abort
    assign timed_out  = tmo_hit && ((in_paint && !paint_done) || (in_flash && !flash_done));

    assign mem_addr = in_paint ? paint_addr : in_flash ? flash_addr : '0;
    assign mem_data = in_paint ? paint_color : '0;
    assign mem_wren = in_paint && paint_we && in_range;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = (working && !working_q) ? PAINT : IDLE;
            PAINT: state_d = paint_done ? GAP : timed_out ? IDLE : PAINT;
            GAP:   state_d = FLASH;
            FLASH: state_d = flash_done ? (working ? PAINT : IDLE) : timed_out ? IDLE : FLASH;
        endcase
        // restarts on every phase entry, so it only advances while a phase is held
        tmo_d = (state_d == state_q && (in_paint || in_flash)) ? tmo_q + TW'(1) : '0;
    end

    always_ff @(posedge Clck or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            working_q     <= 1'b0;
            tmo_q         <= '0;
            paint_start_q <= 1'b0;
            flash_start_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            err_range_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            working_q     <= working;
            tmo_q         <= tmo_d;
            paint_start_q <= state_d == PAINT && !in_paint;
            flash_start_q <= state_d == FLASH && !in_flash;
            busy_q        <= state_d != IDLE;
            frame_count_q <= frame_count_q + 8'(frame_done);
            err_range_q   <= err_range_q || bad_write;
            err_timeout_q <= err_timeout_q || timed_out;
        end
    end

    assign paint_start = paint_start_q;
    assign flash_start = flash_start_q;
    assign busy        = busy_q;
    assign phase       = state_q;
    assign frame_count = frame_count_q;
    assign err_range   = err_range_q;
    assign err_timeout = err_timeout_q;
endmodule
